muldiv: RTL and testbench
=========================

# muldiv

Iterative multiply/divide unit for the 32-bit MIPS datapath; owns the architectural HI/LO register pair. Executes MULT, MULTU, DIV, DIVU over multiple cycles and services MTHI/MTLO writes. The ALU and writeback path read `hi`/`lo` combinationally for MFHI/MFLO, and the control unit stalls on `busy`.

## Interface
- `n`, 32: operand width; HI and LO are each `n` bits.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe, sampled on a rising edge.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- `a`  in  n  multiplicand / dividend / MTHI-MTLO source.
- `b`  in  n  multiplier / divisor.
- `busy`  out  1  operation in flight; new `start` ignored.
- `done`  out  1  one-cycle pulse when HI/LO hold the new result.
- `hi`  out  n  HI register.
- `lo`  out  n  LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE + `start` + mult/div op: latch `|a|`, `|b|` (signed ops) or raw values (unsigned ops), latch sign flags, clear iteration counter, go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, `n` cycles, then FIX.
- FIX: apply sign correction; write HI/LO; go to IDLE; `done`=1 in the following cycle.
- Multiply: 2n-bit product; HI = upper n bits, LO = lower n bits. Signed result negated (two's complement over 2n bits) when operand signs differ.
- Divide: LO = quotient, HI = remainder. Signed: quotient negated when signs differ; remainder takes the sign of the dividend.
- Divide by zero (any sign): LO = all ones, HI = `a` unchanged; takes full latency; no sign correction.
- Signed overflow (-2^(n-1) / -1): LO = 0x80000000, HI = 0 (wraps).
- MTHI/MTLO in IDLE: write `a` to HI/LO on the sampling edge; no `busy`, no `done`.
- No-op codes: no effect.
- `start` while `busy`: ignored; HI/LO and in-flight op unaffected.
- `hi`/`lo` keep their old values throughout RUN; they change only at FIX.

## Timing
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- `start` sampled at edge E0.
- `busy`=1 from after E0 through edge E0+n+1.
- HI/LO written at edge E0+n+1 (34 for n=32).
- `done`=1 for exactly one cycle after E0+n+1, with `busy`=0.
- `start` in the `done` cycle is accepted (back-to-back issue).
- `rst_n` low mid-operation aborts immediately. All outputs return to reset values, and no `done` is issued.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath built; DIV/DIVU behave as above.
- `MULDIV_DIV_EN` undefined: divider logic omitted.
  - DIV/DIVU never assert `busy`.
  - `done` pulses the cycle after sampling.
  - HI/LO unchanged.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` enum for the op codes.
  - `muldiv_state_t` enum (IDLE/RUN/FIX).
  - Width constant for the iteration counter: `$clog2(n)+1`.
- One natural sub-module, `muldiv_signfix`: combinational absolute-value and conditional two's-complement negate, shared by operand entry and result correction.

## Test plan
- Reset: assert `rst_n`=0 asynchronously -> `hi`=`lo`=0, `busy`=`done`=0 with no clock edge.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` for 1 cycle. MULT a=-3, b=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV a=-7, b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=0 -> `lo`=0xFFFFFFFF, `hi`=7. DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MULTU 6×7, then `start` with MTLO a=0x55 at cycle 10 -> ignored; final `lo`=42, `hi`=0. Next op issued in the `done` cycle -> accepted.
- MTHI a=0x1234 in IDLE -> `hi`=0x1234 after one edge, `busy` never high. Reset asserted at cycle 20 of a MULT -> outputs zero, no `done`.
- Build without `MULDIV_DIV_EN`: DIVU 9/3 -> `done` next cycle, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MULDIV_N = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP0  = 3'b110,
        OP_NOP1  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_t;

    // Iteration counter must be able to hold the full step count.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; doubles as absolute value when
// neg is driven by the operand's sign bit.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int w = MULDIV_N
) (
    input  logic [w-1:0] x,
    input  logic         neg,
    output logic [w-1:0] y
);

    assign y = neg ? ('0 - x) : x;

endmodule

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one step per cycle.
// Define MULDIV_DIV_EN to build the divider datapath.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int n = MULDIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo
);

    localparam int CW = cnt_width(n);

    muldiv_op_t      opc;
    muldiv_state_t   state;
    logic [CW-1:0]   cnt;
    logic [2*n-1:0]  acc;
    logic [n-1:0]    opb;
    logic            negq;

    logic            op_mul, op_div, op_sgn, dz, use_abs;
    logic [n-1:0]    abs_a, abs_b;
    logic [n:0]      mul_sum;
    logic [2*n-1:0]  mul_res;

    assign opc     = muldiv_op_t'(op);
    assign op_mul  = (opc == OP_MULT) || (opc == OP_MULTU);
    assign op_div  = (opc == OP_DIV)  || (opc == OP_DIVU);
    assign op_sgn  = (opc == OP_MULT) || (opc == OP_DIV);
    assign dz      = op_div && (b == '0);
    // Divide-by-zero runs on raw operands so the remainder comes out as a.
    assign use_abs = op_sgn && !dz;

    muldiv_signfix #(.w(n)) u_abs_a (.x(a), .neg(use_abs & a[n-1]), .y(abs_a));
    muldiv_signfix #(.w(n)) u_abs_b (.x(b), .neg(use_abs & b[n-1]), .y(abs_b));

    // acc = {partial product, multiplier}; multiplicand held in opb.
    assign mul_sum = {1'b0, acc[2*n-1:n]} + (acc[0] ? {1'b0, opb} : '0);
    muldiv_signfix #(.w(2*n)) u_fix_mul (.x(acc), .neg(negq), .y(mul_res));

`ifdef MULDIV_DIV_EN
    logic            is_div, negr;
    logic [n+1:0]    div_diff;
    logic [n-1:0]    quo_res, rem_res;

    // acc = {remainder, dividend/quotient}; divisor held in opb.
    assign div_diff = {1'b0, acc[2*n-1:n-1]} - {2'b00, opb};
    muldiv_signfix #(.w(n)) u_fix_quo (.x(acc[n-1:0]),   .neg(negq), .y(quo_res));
    muldiv_signfix #(.w(n)) u_fix_rem (.x(acc[2*n-1:n]), .neg(negr), .y(rem_res));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            opb   <= '0;
            negq  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
`ifdef MULDIV_DIV_EN
            is_div <= 1'b0;
            negr   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (op_mul) begin
                            acc   <= {{n{1'b0}}, abs_b};
                            opb   <= abs_a;
                            negq  <= use_abs & (a[n-1] ^ b[n-1]);
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
`ifdef MULDIV_DIV_EN
                            is_div <= 1'b0;
`endif
                        end else if (op_div) begin
`ifdef MULDIV_DIV_EN
                            acc    <= {{n{1'b0}}, abs_a};
                            opb    <= abs_b;
                            negq   <= use_abs & (a[n-1] ^ b[n-1]);
                            negr   <= use_abs & a[n-1];
                            is_div <= 1'b1;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= RUN;
`else
                            done <= 1'b1;
`endif
                        end else if (opc == OP_MTHI) begin
                            hi <= a;
                        end else if (opc == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        if (div_diff[n+1])
                            acc <= {acc[2*n-2:0], 1'b0};
                        else
                            acc <= {div_diff[n-1:0], acc[n-2:0], 1'b1};
                    end else begin
                        acc <= {mul_sum, acc[n-1:1]};
                    end
`else
                    acc <= {mul_sum, acc[n-1:1]};
`endif
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(n - 1))
                        state <= FIX;
                end
                FIX: begin
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        hi <= rem_res;
                        lo <= quo_res;
                    end else begin
                        {hi, lo} <= mul_res;
                    end
`else
                    {hi, lo} <= mul_res;
`endif
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Directed-vector bench for muldiv; expectations follow the MULDIV_DIV_EN build setting.
module tb_muldiv;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'b111;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mhi   = '0;
    logic [31:0] mlo   = '0;
    logic        seen;

    muldiv #(.n(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // lat counts edges from the sampling edge (1) to the edge after which done is seen.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit inject, output int lat);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (inject && lat == 10) begin
                op = 3'b101; a = 32'h55; start = 1'b1;
            end
            if (inject && lat == 11)
                start = 1'b0;
            if (lat == 20) begin
                check("mid_hi", hi, mhi);
                check("mid_lo", lo, mlo);
                check("mid_busy", busy, 1);
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, input int exp_lat, input logic [31:0] eh,
                             input logic [31:0] el, input bit inject, input bit hold);
        int lat;
        run_op(o, x, y, inject, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        mhi = eh;
        mlo = el;
        if (hold) begin
            @(posedge clk); #1;
            check({tag, "_done1"}, done, 0);
        end
    endtask

    initial begin
        #2;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // MTHI / MTLO from IDLE
        @(negedge clk) begin op = 3'b100; a = 32'h1234; start = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0;
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", busy, 0);
        @(posedge clk); #1;
        check("mthi_done", done, 0);
        check("mthi_busy2", busy, 0);
        @(negedge clk) begin op = 3'b101; a = 32'h55AA; start = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo_lo", lo, 32'h55AA);
        check("mtlo_hi", hi, 32'h1234);

        // No-op code leaves state alone
        @(negedge clk) begin op = 3'b110; a = 32'hDEAD; start = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0;
        check("nop_hi", hi, 32'h1234);
        check("nop_lo", lo, 32'h55AA);
        check("nop_busy", busy, 0);
        @(posedge clk); #1;
        check("nop_done", done, 0);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        mhi = '0; mlo = '0;
        @(negedge clk) rst_n = 1'b1;

        run_check("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 34,
                  32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
        run_check("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd5, 34,
                  32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b1);

        // Reset in the middle of a MULT
        op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_hi", hi, 0);
        check("mrst_lo", lo, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        mhi = '0; mlo = '0;
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | done | busy;
        end
        check("mrst_quiet", seen, 0);

        // Start ignored while busy, then back-to-back issue in the done cycle
        run_check("multu_6x7", 3'b001, 32'd6, 32'd7, 34, 32'd0, 32'd42, 1'b1, 1'b0);
        run_check("mult_b2b", 3'b000, 32'd2, 32'd3, 34, 32'd0, 32'd6, 1'b0, 1'b1);

`ifdef MULDIV_DIV_EN
        run_check("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 34,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
        run_check("divu_dz", 3'b011, 32'd7, 32'd0, 34,
                  32'd7, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_check("div_dz", 3'b010, 32'hFFFFFFF9, 32'd0, 34,
                  32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_check("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 34,
                  32'd0, 32'h80000000, 1'b0, 1'b1);
        run_check("divu_100", 3'b011, 32'd100, 32'd7, 34,
                  32'd2, 32'd14, 1'b0, 1'b1);
`else
        run_check("divu_off", 3'b011, 32'd9, 32'd3, 1, 32'd0, 32'd6, 1'b0, 1'b1);
        run_check("div_off", 3'b010, 32'hFFFFFFF9, 32'd2, 1, 32'd0, 32'd6, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
